// File: rtl/pipe_pkg.sv
// Shared types for the pipeline skid register.
// Occupancy encoding doubles as the o_occ entry count.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_occ_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-slot skid register (main + skid) with a registered ready and bubble tagging.
// Build macro PIPE_SKID_BUBBLE_ZERO_EN: zero bubble payloads and blank o_data while idle.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DROP_BUBBLES = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic              i_bubble,
    input  logic              i_kill,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_valid,
    output logic              o_bubble,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_ready,
    output logic [1:0]        o_occ
);

    localparam bit DROP = (DROP_BUBBLES != 0);

    pipe_occ_e         state_q;
    pipe_occ_e         state_d;
    logic              ready_q;
    logic              main_bub;
    logic [DATA_W-1:0] main_data;
    logic              skid_bub;
    logic [DATA_W-1:0] skid_data;

    logic              accept;
    logic              in_bub;
    logic              store;
    logic              drain;
    logic [DATA_W-1:0] in_data;
    logic              ld_main;
    logic              ld_skid;
    logic              mv_skid;

    assign accept = i_valid & ready_q;
    assign in_bub = i_bubble | i_kill;
    assign store  = accept & ~(DROP & in_bub);
    assign drain  = (state_q != EMPTY) & i_ready;

`ifdef PIPE_SKID_BUBBLE_ZERO_EN
    assign in_data = in_bub ? '0 : i_data;
`else
    assign in_data = i_data;
`endif

    always_comb begin
        state_d = state_q;
        ld_main = 1'b0;
        ld_skid = 1'b0;
        mv_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (store) begin
                    state_d = ONE;
                    ld_main = 1'b1;
                end
            end
            ONE: begin
                if (store && !drain) begin
                    state_d = FULL;
                    ld_skid = 1'b1;
                end else if (store && drain) begin
                    ld_main = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // ready is low here, so only a drain can change anything
                if (drain) begin
                    state_d = ONE;
                    mv_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else if (i_flush) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            main_bub  <= 1'b0;
            main_data <= '0;
            skid_bub  <= 1'b0;
            skid_data <= '0;
        end else if (!i_flush) begin
            if (ld_main) begin
                main_bub  <= in_bub;
                main_data <= in_data;
            end else if (mv_skid) begin
                main_bub  <= skid_bub;
                main_data <= skid_data;
            end
            if (ld_skid) begin
                skid_bub  <= in_bub;
                skid_data <= in_data;
            end
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = (state_q != EMPTY);
    assign o_bubble = main_bub & o_valid;
    assign o_occ    = state_q;

`ifdef PIPE_SKID_BUBBLE_ZERO_EN
    assign o_data = o_valid ? main_data : '0;
`else
    assign o_data = main_data;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: streaming, back-pressure, kill/bubble,
// flush and reset-while-full, on a keep-bubbles and a drop-bubbles instance.
module tb_pipe_skid_reg;
    import pipe_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_reset, i_flush, i_valid, i_bubble, i_kill, i_ready;
    logic [7:0] i_data;

    logic       rdy0, val0, bub0;
    logic [7:0] dat0;
    logic [1:0] occ0;
    logic       rdy1, val1, bub1;
    logic [7:0] dat1;
    logic [1:0] occ1;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] bub_exp55, bub_exp66;

    always #5 i_clk = ~i_clk;

    pipe_skid_reg #(.DATA_W(8), .DROP_BUBBLES(0)) dut0 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .i_bubble(i_bubble), .i_kill(i_kill),
        .i_data(i_data), .o_ready(rdy0), .o_valid(val0),
        .o_bubble(bub0), .o_data(dat0), .i_ready(i_ready), .o_occ(occ0)
    );

    pipe_skid_reg #(.DATA_W(8), .DROP_BUBBLES(1)) dut1 (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_valid(i_valid), .i_bubble(i_bubble), .i_kill(i_kill),
        .i_data(i_data), .o_ready(rdy1), .o_valid(val1),
        .o_bubble(bub1), .o_data(dat1), .i_ready(i_ready), .o_occ(occ1)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out0(input string tag, input logic v, input logic b,
                        input logic [7:0] d, input logic [1:0] o,
                        input logic r);
        chk({tag, ".valid"}, 32'(val0), 32'(v));
        chk({tag, ".bubble"}, 32'(bub0), 32'(b));
        chk({tag, ".data"}, 32'(dat0), 32'(d));
        chk({tag, ".occ"}, 32'(occ0), 32'(o));
        chk({tag, ".ready"}, 32'(rdy0), 32'(r));
    endtask

    initial begin
`ifdef PIPE_SKID_BUBBLE_ZERO_EN
        bub_exp55 = 8'h00;
        bub_exp66 = 8'h00;
`else
        bub_exp55 = 8'h55;
        bub_exp66 = 8'h66;
`endif
        i_reset = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        i_bubble = 1'b0; i_kill = 1'b0; i_ready = 1'b0;
        i_data = 8'h00;
        tick();
        out0("reset", 0, 0, 8'h00, 2'd0, 1);

        // streaming at full rate
        i_reset = 1'b1; i_ready = 1'b1; i_valid = 1'b1;
        i_data = 8'h11; tick();
        out0("s11", 1, 0, 8'h11, 2'd1, 1);
        i_data = 8'h22; tick();
        out0("s22", 1, 0, 8'h22, 2'd1, 1);
        i_data = 8'h33; tick();
        out0("s33", 1, 0, 8'h33, 2'd1, 1);
        i_valid = 1'b0; tick();
        out0("sidle", 0, 0, 8'h33, 2'd0, 1);

        // back-pressure fills both slots
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 8'h0A; tick();
        out0("bpA", 1, 0, 8'h0A, 2'd1, 1);
        i_data = 8'h0B; tick();
        out0("bpB", 1, 0, 8'h0A, 2'd2, 0);
        i_data = 8'h0C; tick();
        out0("bpC", 1, 0, 8'h0A, 2'd2, 0);
        i_valid = 1'b0; tick();
        out0("bphold", 1, 0, 8'h0A, 2'd2, 0);
        i_valid = 1'b1; i_ready = 1'b1; tick();
        out0("drB", 1, 0, 8'h0B, 2'd1, 1);
        tick();
        out0("drC", 1, 0, 8'h0C, 2'd1, 1);
        i_valid = 1'b0; tick();
        out0("drE", 0, 0, 8'h0C, 2'd0, 1);

        // flush while full with a same-cycle offer
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 8'h01; tick();
        i_data = 8'h02; tick();
        out0("f_full", 1, 0, 8'h01, 2'd2, 0);
        i_flush = 1'b1; i_ready = 1'b1; i_data = 8'h03; tick();
        chk("flush.valid", 32'(val0), 32'd0);
        chk("flush.occ", 32'(occ0), 32'd0);
        chk("flush.ready", 32'(rdy0), 32'd1);
        i_flush = 1'b0; i_valid = 1'b0; tick();
        chk("flush.no3", 32'(val0), 32'd0);

        // reset while full, then first-accept latency
        i_ready = 1'b0; i_valid = 1'b1;
        i_data = 8'h04; tick();
        i_data = 8'h05; tick();
        chk("rf.occ", 32'(occ0), 32'd2);
        i_reset = 1'b0; tick();
        out0("rf", 0, 0, 8'h00, 2'd0, 1);
        i_reset = 1'b1; i_data = 8'h77; tick();
        out0("rf.lat", 1, 0, 8'h77, 2'd1, 1);

        // kill / bubble, both instances from reset
        i_valid = 1'b0; i_reset = 1'b0; tick();
        i_reset = 1'b1; i_valid = 1'b1; i_kill = 1'b1;
        i_data = 8'h55; tick();
        out0("kill0", 1, 1, bub_exp55, 2'd1, 1);
        chk("kill1.valid", 32'(val1), 32'd0);
        chk("kill1.occ", 32'(occ1), 32'd0);
        chk("kill1.ready", 32'(rdy1), 32'd1);
        i_kill = 1'b0; i_bubble = 1'b1; i_ready = 1'b1;
        i_data = 8'h66; tick();
        out0("bub0", 1, 1, bub_exp66, 2'd1, 1);
        chk("bub1.valid", 32'(val1), 32'd0);
        i_bubble = 1'b0; i_data = 8'h99; tick();
        out0("norm0", 1, 0, 8'h99, 2'd1, 1);
        chk("norm1.valid", 32'(val1), 32'd1);
        chk("norm1.bubble", 32'(bub1), 32'd0);
        chk("norm1.data", 32'(dat1), 32'h99);
        chk("norm1.occ", 32'(occ1), 32'd1);

        // kill beats bubble and payload together
        i_kill = 1'b1; i_bubble = 1'b1; i_data = 8'hA5; tick();
        chk("kb0.bubble", 32'(bub0), 32'd1);
        chk("kb1.valid", 32'(val1), 32'd0);
        i_kill = 1'b0; i_bubble = 1'b0; i_valid = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits (>=1).
REQ-002 Parameter DROP_BUBBLES, default 0; 0 = bubbles/kills occupy a slot and propagate with o_bubble=1, 1 = discarded at input.
REQ-003 i_clk  in  1  clock; all state updates on rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-low.
REQ-005 i_flush  in  1  discard all held entries and the same-cycle input.
REQ-006 i_valid  in  1  upstream entry offered.
REQ-007 i_bubble  in  1  offered entry is a bubble.
REQ-008 i_kill  in  1  offered entry is to be turned into a bubble.
REQ-009 i_data  in  DATA_W  offered payload.
REQ-010 o_ready  out  1  registered; upstream transfer occurs when i_valid && o_ready.
REQ-011 o_valid  out  1  downstream entry present.
REQ-012 o_bubble  out  1  presented entry is a bubble.
REQ-013 o_data  out  DATA_W  presented payload.
REQ-014 i_ready  in  1  downstream transfer occurs when o_valid && i_ready.
REQ-015 o_occ  out  2  entries held: 0, 1 or 2.

Function
REQ-016 Two storage slots, main (drives outputs) and skid; occupancy states EMPTY, ONE, FULL.
REQ-017 Transitions: EMPTY + accept -> ONE; ONE + accept, no drain -> FULL (entry written to skid); ONE + drain, no accept -> EMPTY; ONE + accept + drain -> ONE (main reloaded); FULL + drain -> ONE (skid moves to main); otherwise hold.
REQ-018 o_ready = 1 exactly when state != FULL, taken from a register, never combinationally from i_ready.
REQ-019 Latency: an entry accepted in cycle N is presented on o_valid in cycle N+1 when the slots were empty.
REQ-020 Throughput: one entry per cycle sustained while i_ready=1; no bubble cycles are inserted.
REQ-021 Ordering is strictly FIFO; no entry is duplicated or lost except by flush or DROP_BUBBLES.
REQ-022 Accepted entry with i_kill=1 or i_bubble=1 is stored with bubble flag 1 (DROP_BUBBLES=0) or not stored (DROP_BUBBLES=1, o_ready unaffected).
REQ-023 i_kill has priority over payload; a killed entry never presents o_bubble=0.
REQ-024 i_flush=1 forces state EMPTY next cycle, o_valid=0, o_occ=0, o_ready=1; the same-cycle input is not stored and same-cycle downstream handshake is not counted.
REQ-025 Priority per edge: reset > flush > normal update.
REQ-026 While i_valid=0 and i_ready=0 all outputs hold their values.
REQ-027 o_data is stable while o_valid=1 and i_ready=0.

Reset
REQ-028 With i_reset=0 at an edge: state EMPTY, o_valid=0, o_bubble=0, o_data=0, skid data=0, o_occ=0, o_ready=1.
REQ-029 Reset during FULL discards both entries; the first accept after release follows REQ-019.

Configuration
REQ-030 Macro PIPE_SKID_BUBBLE_ZERO_EN defined: payload of every bubble/killed entry is stored as all-zero, and o_data=0 whenever o_valid=0.
REQ-031 Macro absent: bubble payloads stored as given; o_data while o_valid=0 is don't-care but never X after reset.

Structure
REQ-032 Occupancy enum typedef pipe_occ_e (EMPTY/ONE/FULL) lives in shared package pipe_pkg.
REQ-033 Single module; no sub-module, both slots inline.

Verification
REQ-034 Stream 0x11,0x22,0x33 with i_ready=1 -> o_data 0x11,0x22,0x33 in cycles N+1..N+3, o_occ=1.
REQ-035 i_ready=0 for 3 cycles while offering 0xA,0xB,0xC -> 0xA,0xB held, o_ready=0 at occ=2, then i_ready=1 drains 0xA,0xB,0xC in order.
REQ-036 Offer 0x55 with i_kill=1, macro defined, DROP_BUBBLES=0 -> o_valid=1, o_bubble=1, o_data=0.
REQ-037 Same stimulus with DROP_BUBBLES=1 -> o_valid stays 0, o_occ stays 0.
REQ-038 FULL (0x1,0x2) plus i_flush with i_valid=1 data 0x3 -> next cycle o_valid=0, o_occ=0, o_ready=1; 0x3 never appears.
REQ-039 i_reset=0 while FULL -> next cycle all outputs at REQ-028 values.
